sram_bist: RTL and testbench

March C- built-in self-test controller for the 16x8 synchronous read/write memory (`rwmem`) used in the memory subsystem. It sits directly upstream of the RAM and drives its `addr`/`din`/`we` pins through a fixed march sequence. It checks every read word returned on the RAM's `dout` and reports pass/fail, with the first failing address, data and element. It connects to the RAM port-for-port, and a top-level mux hands the RAM back to functional logic when `busy` is low.

---
 rtl/sram_bist.sv | 193 +++++++++++++++++++
 tb/tb_sram_bist.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bist.sv
// March C- self-test controller for a small synchronous single-port RAM.
// Drives the RAM through six march elements and reports the first mismatch.
module sram_bist #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [2:0]        fail_elem,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR0  = 3'd1,
        S_RD   = 3'd2,
        S_CMPW = 3'd3,
        S_RDF  = 3'd4,
        S_CMPF = 3'd5,
        S_FIN  = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [DATA_W-1:0] BG0       = '0;
    localparam logic [DATA_W-1:0] BG1       = '1;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic              we_q;
    logic [2:0]        elem_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic [DATA_W-1:0] fail_data_q;
    logic [2:0]        fail_elem_q;

    // Element attributes: M3/M4 run downwards; odd elements write B1, even read B1.
    logic              elem_down;
    logic [ADDR_W-1:0] elem_last;
    logic [ADDR_W-1:0] addr_step;
    logic [DATA_W-1:0] rd_bg;
    logic [DATA_W-1:0] wr_bg;
    logic [ADDR_W-1:0] next_elem_start;

    always_comb begin
        elem_down       = (elem_q == 3'd3) || (elem_q == 3'd4);
        elem_last       = elem_down ? ADDR_ZERO : ADDR_LAST;
        addr_step       = elem_down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
        rd_bg           = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? BG1 : BG0;
        wr_bg           = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? BG1 : BG0;
        next_elem_start = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_LAST : ADDR_ZERO;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            din_q       <= '0;
            we_q        <= 1'b0;
            elem_q      <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_elem_q <= 3'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    we_q <= 1'b0;
                    if (start) begin
                        state_q     <= S_WR0;
                        busy_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        fail_addr_q <= '0;
                        fail_data_q <= '0;
                        fail_elem_q <= 3'd0;
                        elem_q      <= 3'd0;
                        addr_q      <= '0;
                        din_q       <= BG0;
                        we_q        <= 1'b1;
                    end
                end
                S_WR0: begin
                    if (addr_q == ADDR_LAST) begin
                        state_q <= S_RD;
                        elem_q  <= 3'd1;
                        addr_q  <= '0;
                        we_q    <= 1'b0;
                    end else begin
                        addr_q <= addr_q + ADDR_ONE;
                    end
                end
                S_RD: begin
                    state_q <= S_CMPW;
                    we_q    <= 1'b1;
                    din_q   <= wr_bg;
                end
                S_CMPW: begin
                    we_q <= 1'b0;
                    if (mem_dout != rd_bg) begin
                        state_q     <= S_FIN;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        fail_addr_q <= addr_q;
                        fail_data_q <= mem_dout;
                        fail_elem_q <= elem_q;
                    end else if (addr_q == elem_last) begin
                        if (elem_q == 3'd4) begin
                            state_q <= S_RDF;
                            elem_q  <= 3'd5;
                            addr_q  <= '0;
                        end else begin
                            state_q <= S_RD;
                            elem_q  <= elem_q + 3'd1;
                            addr_q  <= next_elem_start;
                        end
                    end else begin
                        state_q <= S_RD;
                        addr_q  <= addr_step;
                    end
                end
                S_RDF: begin
                    // Data on mem_dout belongs to the previous address; none yet at address 0.
                    if ((addr_q != ADDR_ZERO) && (mem_dout != BG0)) begin
                        state_q     <= S_FIN;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        fail_addr_q <= addr_q - ADDR_ONE;
                        fail_data_q <= mem_dout;
                        fail_elem_q <= elem_q;
                    end else if (addr_q == ADDR_LAST) begin
                        state_q <= S_CMPF;
                    end else begin
                        addr_q <= addr_q + ADDR_ONE;
                    end
                end
                S_CMPF: begin
                    state_q <= S_FIN;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    if (mem_dout != BG0) begin
                        pass_q      <= 1'b0;
                        fail_addr_q <= addr_q;
                        fail_data_q <= mem_dout;
                        fail_elem_q <= elem_q;
                    end else begin
                        pass_q <= 1'b1;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    we_q    <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr    = addr_q;
    assign mem_din     = din_q;
    assign mem_we      = we_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_addr   = fail_addr_q;
    assign fail_data   = fail_data_q;
    assign fail_elem   = fail_elem_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_bist.sv
// Bench for sram_bist: behavioural 16x8 RAM with injectable faults and an
// expected-result queue scored on each done pulse.
module tb_sram_bist;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int RW = 25;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic [DW-1:0] mem_dout;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic [2:0]    fail_elem;
    logic [2:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int fault_mode = 0;

    logic [RW-1:0] exp_q[$];
    logic [DW-1:0] ram[16];

    sram_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
        .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_data(fail_data), .fail_elem(fail_elem),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // RAM model: read-first synchronous port; faults 1/2 are stuck bits, 3 couples 5->4
    function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (fault_mode == 1 && a == 4'd9) return d | 8'h08;
        if (fault_mode == 2 && a == 4'd2) return d & 8'hFE;
        return d;
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_din;
            if (fault_mode == 3 && mem_addr == 4'd5) ram[4] <= mem_din;
        end
        mem_dout <= faulty(mem_addr, ram[mem_addr]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] make_exp(input logic p, input logic [AW-1:0] a,
                                               input logic [DW-1:0] d, input logic [2:0] e,
                                               input int cyc);
        logic [8:0] c;
        c = 9'(cyc);
        return {p, a, d, e, c};
    endfunction

    // driver: pulse start so the next edge is cycle 0; returns at the cycle-1 negedge
    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_clears_pass", 32'(pass), 32'd0);
    endtask

    // monitor: called at the cycle-1 negedge, returns at the negedge of the done cycle
    task automatic wait_done(output int done_cyc, output int busy_cnt, output int wr_cnt,
                             output int rd_cnt, output int seq_bad, output logic [AW-1:0] last_wr);
        done_cyc = 0; busy_cnt = 0; wr_cnt = 0; rd_cnt = 0; seq_bad = 0; last_wr = '1;
        for (int cyc = 1; cyc < 400; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (busy) begin
                if (busy_cnt < 16 && !(mem_we && mem_addr == 4'(busy_cnt) && mem_din == 8'h00))
                    seq_bad++;
                if (mem_we) begin
                    wr_cnt++;
                    last_wr = mem_addr;
                end else begin
                    rd_cnt++;
                end
                busy_cnt++;
            end
            @(negedge clk);
        end
    endtask

    // scoreboard: pop the expected result and compare with what the DUT reports
    task automatic score(input int done_cyc);
        logic [RW-1:0] e;
        if (exp_q.size() == 0) begin
            check("sb_nonempty", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("done_cycle", 32'(done_cyc), 32'(e[8:0]));
        check("pass", 32'(pass), 32'(e[24]));
        check("busy_at_done", 32'(busy), 32'd0);
        if (!e[24]) begin
            check("fail_addr", 32'(fail_addr), 32'(e[23:20]));
            check("fail_data", 32'(fail_data), 32'(e[19:12]));
            check("fail_elem", 32'(fail_elem), 32'(e[11:9]));
        end
    endtask

    task automatic full_pass_checks(input int busy_cnt, input int wr_cnt, input int rd_cnt,
                                    input int seq_bad, input logic [AW-1:0] last_wr);
        check("busy_cycles", 32'(busy_cnt), 32'd161);
        check("write_count", 32'(wr_cnt), 32'd80);
        check("read_count", 32'(rd_cnt), 32'd81);
        check("m0_write_seq", 32'(seq_bad), 32'd0);
        check("last_write_addr", 32'(last_wr), 32'd0);
    endtask

    function automatic logic [30:0] all_outs();
        return {busy, done, pass, mem_we, mem_addr, mem_din, fail_addr, fail_data, fail_elem};
    endfunction

    initial begin
        int dc, bc, wc, rc, sb, idle_busy, done_seen;
        logic [AW-1:0] lw;

        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(all_outs()), 32'd0);
        rst = 1'b0;

        // fault-free run
        fault_mode = 0;
        exp_q.push_back(make_exp(1'b1, 4'd0, 8'h00, 3'd0, 162));
        launch();
        wait_done(dc, bc, wc, rc, sb, lw);
        score(dc);
        full_pass_checks(bc, wc, rc, sb, lw);
        repeat (3) @(negedge clk);
        check("pass_held", 32'(pass), 32'd1);
        check("done_single_pulse", 32'(done), 32'd0);

        // stuck-at faults and coupling fault
        fault_mode = 1;
        exp_q.push_back(make_exp(1'b0, 4'd9, 8'h08, 3'd1, 37));
        launch();
        wait_done(dc, bc, wc, rc, sb, lw);
        score(dc);

        fault_mode = 2;
        exp_q.push_back(make_exp(1'b0, 4'd2, 8'hFE, 3'd2, 55));
        launch();
        wait_done(dc, bc, wc, rc, sb, lw);
        score(dc);

        fault_mode = 3;
        exp_q.push_back(make_exp(1'b0, 4'd4, 8'hFF, 3'd3, 105));
        launch();
        wait_done(dc, bc, wc, rc, sb, lw);
        score(dc);

        // start while busy, then reset mid-run
        fault_mode = 0;
        done_seen = 0;
        launch();
        for (int c = 2; c <= 50; c++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 52; c <= 80; c++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("busy_before_reset", 32'(busy), 32'd1);
        check("no_done_before_reset", 32'(done_seen), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_reset_outputs", 32'(all_outs()), 32'd0);
        rst = 1'b0;
        exp_q.push_back(make_exp(1'b1, 4'd0, 8'h00, 3'd0, 162));
        launch();
        wait_done(dc, bc, wc, rc, sb, lw);
        score(dc);
        full_pass_checks(bc, wc, rc, sb, lw);

        // reset wins over start, then start held high across done
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_start_busy", 32'(busy), 32'd0);
        check("rst_start_we", 32'(mem_we), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(make_exp(1'b1, 4'd0, 8'h00, 3'd0, 162));
        wait_done(dc, bc, wc, rc, sb, lw);
        score(dc);
        @(negedge clk);
        check("held_start_idle_gap", 32'(busy), 32'd0);
        @(negedge clk);
        check("held_start_retrigger", 32'(busy), 32'd1);
        start = 1'b0;
        exp_q.push_back(make_exp(1'b1, 4'd0, 8'h00, 3'd0, 162));
        wait_done(dc, bc, wc, rc, sb, lw);
        score(dc);
        idle_busy = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy) idle_busy++;
        end
        check("no_extra_run", 32'(idle_busy), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
